// File: rtl/button_write_pkg.sv
// Shared types and default constants for the button write-source block.
package button_write_pkg;

   // Debounce FSM states.
   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } deb_state_e;

   localparam int DEFAULT_DATA_WIDTH      = 8;
   localparam int DEFAULT_ADDR_WIDTH      = 8;
   localparam int DEFAULT_MMIO_ADDR       = 255;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus press/release debounce FSM.
// press_event_o is a one-cycle combinational strobe, high in the cycle whose
// closing edge moves the FSM from PRESS_WAIT into PRESSED.
module button_debouncer
   import button_write_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic btn_i,
   output logic press_event_o,
   output logic pressed_o
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   deb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Bring the asynchronous button level into the clock domain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

   // FSM state and stability counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: a level must hold DEBOUNCE_CYCLES samples to be accepted.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      press_event_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (sync2_q) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!sync2_q) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_MAX) begin
               state_d       = PRESSED;
               press_event_o = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!sync2_q) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end
         end
         RELEASE_WAIT: begin
            // A return to high here is release bounce, not a new press.
            if (sync2_q) begin
               state_d = PRESSED;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pressed_o = (state_q == PRESSED) || (state_q == RELEASE_WAIT);

endmodule

// File: rtl/button_write_ctrl.sv
// Write-source stage for the downstream data register: merges debounced
// button increments with core stores to the MMIO address onto one write port.
module button_write_ctrl
   import button_write_pkg::*;
#(
   parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int MMIO_ADDR       = DEFAULT_MMIO_ADDR,
   parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  button,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic                  reg_w_en,
   input  logic [DATA_WIDTH-1:0] store_data,
   output logic [DATA_WIDTH-1:0] w_data,
   output logic                  w_en,
   output logic                  pressed
);

   localparam logic [ADDR_WIDTH-1:0] MMIO_MATCH = ADDR_WIDTH'(MMIO_ADDR);

   logic                  press_event;
   logic                  core_store;
   logic [DATA_WIDTH-1:0] count_q, count_d;
   logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
   logic                  w_en_q, w_en_d;
   logic                  pending_q, pending_d;
   logic [DATA_WIDTH-1:0] count_inc;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk_i        (clock),
      .rst_i        (reset),
      .btn_i        (button),
      .press_event_o(press_event),
      .pressed_o    (pressed)
   );

   assign core_store = reg_w_en && (addr == MMIO_MATCH);
   assign count_inc  = count_q + 1'b1;

   // Arbitration: a core store always wins; a colliding press is parked in
   // pending and issued on the first edge without a store, using the new count.
   always_comb begin
      count_d   = count_q;
      w_data_d  = w_data_q;
      w_en_d    = 1'b0;
      pending_d = pending_q;
      if (core_store) begin
         count_d  = store_data;
         w_data_d = store_data;
         w_en_d   = 1'b1;
         if (press_event) begin
            pending_d = 1'b1;
         end
      end else if (press_event || pending_q) begin
         count_d   = count_inc;
         w_data_d  = count_inc;
         w_en_d    = 1'b1;
         pending_d = 1'b0;
      end
   end

   // Registered write port, press counter and pending flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q   <= '0;
         w_data_q  <= '0;
         w_en_q    <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         w_data_q  <= w_data_d;
         w_en_q    <= w_en_d;
         pending_q <= pending_d;
      end
   end

   assign w_data = w_data_q;
   assign w_en   = w_en_q;

endmodule

// File: tb/tb_button_write_ctrl.sv
// Directed bench for button_write_ctrl at default parameters (D=16).
module tb_button_write_ctrl;

   logic       clock;
   logic       reset;
   logic       button;
   logic [7:0] addr;
   logic       reg_w_en;
   logic [7:0] store_data;
   logic [7:0] w_data;
   logic       w_en;
   logic       pressed;

   int tests_run    = 0;
   int tests_failed = 0;

   button_write_ctrl dut (
      .clock     (clock),
      .reset     (reset),
      .button    (button),
      .addr      (addr),
      .reg_w_en  (reg_w_en),
      .store_data(store_data),
      .w_data    (w_data),
      .w_en      (w_en),
      .pressed   (pressed)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Advance n edges, counting write pulses and cycles with pressed high.
   task automatic run_cycles(input int n, output int pulses, output int hi_cnt,
                             output logic [7:0] last_data);
      pulses    = 0;
      hi_cnt    = 0;
      last_data = w_data;
      for (int i = 0; i < n; i++) begin
         tick(1);
         if (w_en === 1'b1) begin
            pulses++;
            last_data = w_data;
         end
         if (pressed === 1'b1) hi_cnt++;
      end
   endtask

   // Clean press held 20 edges, then released long enough to return to IDLE.
   task automatic press_release(output int pulses, output logic [7:0] data);
      int p1, p2, h;
      logic [7:0] d1, d2;
      button = 1'b1;
      run_cycles(20, p1, h, d1);
      button = 1'b0;
      run_cycles(20, p2, h, d2);
      pulses = p1 + p2;
      data   = (p2 != 0) ? d2 : d1;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      button     = 1'b0;
      reg_w_en   = 1'b0;
      addr       = 8'h00;
      store_data = 8'h00;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      button     = 1'b0;
      reg_w_en   = 1'b0;
      addr       = 8'h00;
      store_data = 8'h00;
      tick(2);
      tests_run++;
      if (w_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_w_en: got %b expected 0", w_en);
      end
      tests_run++;
      if (w_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_w_data: got %h expected 00", w_data);
      end
      tests_run++;
      if (pressed !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_pressed: got %b expected 0", pressed);
      end
      reset = 1'b0;
   endtask

   task automatic test_clean_press();
      int p, h;
      logic [7:0] d;
      button = 1'b1;
      tick(18);
      tests_run++;
      if (w_en !== 1'b0 || pressed !== 1'b0) begin
         tests_failed++;
         $display("FAIL press_edge18: got w_en=%b pressed=%b expected 0 0", w_en, pressed);
      end
      tick(1);
      tests_run++;
      if (w_en !== 1'b1 || w_data !== 8'h01) begin
         tests_failed++;
         $display("FAIL press_edge19: got w_en=%b w_data=%h expected 1 01", w_en, w_data);
      end
      tests_run++;
      if (pressed !== 1'b1) begin
         tests_failed++;
         $display("FAIL press_pressed: got %b expected 1", pressed);
      end
      tick(1);
      tests_run++;
      if (w_en !== 1'b0 || w_data !== 8'h01) begin
         tests_failed++;
         $display("FAIL press_edge20: got w_en=%b w_data=%h expected 0 01", w_en, w_data);
      end
      button = 1'b0;
      run_cycles(20, p, h, d);
      tests_run++;
      if (p != 0 || pressed !== 1'b0) begin
         tests_failed++;
         $display("FAIL release: got pulses=%0d pressed=%b expected 0 0", p, pressed);
      end
   endtask

   task automatic test_glitch();
      int p1, p2, h1, h2;
      logic [7:0] d;
      do_reset();
      button = 1'b1;
      run_cycles(10, p1, h1, d);
      button = 1'b0;
      run_cycles(10, p2, h2, d);
      tests_run++;
      if (p1 + p2 != 0 || h1 + h2 != 0) begin
         tests_failed++;
         $display("FAIL glitch: got pulses=%0d pressed_cycles=%0d expected 0 0", p1 + p2, h1 + h2);
      end
      press_release(p1, d);
      tests_run++;
      if (p1 != 1 || d !== 8'h01) begin
         tests_failed++;
         $display("FAIL glitch_then_press: got pulses=%0d data=%h expected 1 01", p1, d);
      end
   endtask

   task automatic test_store_wrap();
      int p;
      logic [7:0] d;
      addr       = 8'hFF;
      store_data = 8'hFE;
      reg_w_en   = 1'b1;
      tick(1);
      reg_w_en = 1'b0;
      tests_run++;
      if (w_en !== 1'b1 || w_data !== 8'hFE) begin
         tests_failed++;
         $display("FAIL store_fe: got w_en=%b w_data=%h expected 1 fe", w_en, w_data);
      end
      tick(1);
      tests_run++;
      if (w_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL store_one_cycle: got w_en=%b expected 0", w_en);
      end
      press_release(p, d);
      tests_run++;
      if (p != 1 || d !== 8'hFF) begin
         tests_failed++;
         $display("FAIL wrap_ff: got pulses=%0d data=%h expected 1 ff", p, d);
      end
      press_release(p, d);
      tests_run++;
      if (p != 1 || d !== 8'h00) begin
         tests_failed++;
         $display("FAIL wrap_00: got pulses=%0d data=%h expected 1 00", p, d);
      end
   endtask

   task automatic test_addr_filter();
      int p;
      logic [7:0] d;
      addr       = 8'hFE;
      store_data = 8'h55;
      reg_w_en   = 1'b1;
      tick(1);
      tests_run++;
      if (w_en !== 1'b0 || w_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL wrong_addr: got w_en=%b w_data=%h expected 0 00", w_en, w_data);
      end
      addr     = 8'hFF;
      reg_w_en = 1'b0;
      tick(1);
      tests_run++;
      if (w_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL no_strobe: got w_en=%b expected 0", w_en);
      end
      press_release(p, d);
      tests_run++;
      if (p != 1 || d !== 8'h01) begin
         tests_failed++;
         $display("FAIL count_kept: got pulses=%0d data=%h expected 1 01", p, d);
      end
   endtask

   task automatic test_back_to_back();
      int p, h;
      logic [7:0] d;
      // Store lands on the press-event edge.
      addr   = 8'hFF;
      button = 1'b1;
      tick(18);
      store_data = 8'h10;
      reg_w_en   = 1'b1;
      tick(1);
      reg_w_en = 1'b0;
      tests_run++;
      if (w_en !== 1'b1 || w_data !== 8'h10) begin
         tests_failed++;
         $display("FAIL collide_store: got w_en=%b w_data=%h expected 1 10", w_en, w_data);
      end
      tick(1);
      tests_run++;
      if (w_en !== 1'b1 || w_data !== 8'h11) begin
         tests_failed++;
         $display("FAIL collide_press: got w_en=%b w_data=%h expected 1 11", w_en, w_data);
      end
      tick(1);
      tests_run++;
      if (w_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL collide_end: got w_en=%b expected 0", w_en);
      end
      button = 1'b0;
      run_cycles(20, p, h, d);
      // Second store on the pending edge pushes the press write out once more.
      button = 1'b1;
      tick(18);
      store_data = 8'h20;
      reg_w_en   = 1'b1;
      tick(1);
      tests_run++;
      if (w_en !== 1'b1 || w_data !== 8'h20) begin
         tests_failed++;
         $display("FAIL pend_store1: got w_en=%b w_data=%h expected 1 20", w_en, w_data);
      end
      store_data = 8'h30;
      tick(1);
      reg_w_en = 1'b0;
      tests_run++;
      if (w_en !== 1'b1 || w_data !== 8'h30) begin
         tests_failed++;
         $display("FAIL pend_store2: got w_en=%b w_data=%h expected 1 30", w_en, w_data);
      end
      tick(1);
      tests_run++;
      if (w_en !== 1'b1 || w_data !== 8'h31) begin
         tests_failed++;
         $display("FAIL pend_press: got w_en=%b w_data=%h expected 1 31", w_en, w_data);
      end
      tick(1);
      tests_run++;
      if (w_en !== 1'b0) begin
         tests_failed++;
         $display("FAIL pend_end: got w_en=%b expected 0", w_en);
      end
      button = 1'b0;
      run_cycles(20, p, h, d);
   endtask

   task automatic test_bounce_and_reset();
      int p1, p2, p3, h2, h3;
      logic [7:0] d;
      do_reset();
      button = 1'b1;
      run_cycles(20, p1, h2, d);
      tests_run++;
      if (p1 != 1 || d !== 8'h01) begin
         tests_failed++;
         $display("FAIL bounce_first: got pulses=%0d data=%h expected 1 01", p1, d);
      end
      button = 1'b0;
      run_cycles(5, p2, h2, d);
      button = 1'b1;
      run_cycles(10, p3, h3, d);
      tests_run++;
      if (p2 + p3 != 0 || h2 + h3 != 15) begin
         tests_failed++;
         $display("FAIL bounce: got pulses=%0d pressed_cycles=%0d expected 0 15", p2 + p3, h2 + h3);
      end
      button = 1'b0;
      run_cycles(20, p2, h2, d);
      // Reset while the debouncer is in PRESS_WAIT.
      button = 1'b1;
      tick(10);
      reset  = 1'b1;
      button = 1'b0;
      tick(1);
      tests_run++;
      if (w_en !== 1'b0 || w_data !== 8'h00 || pressed !== 1'b0) begin
         tests_failed++;
         $display("FAIL midreset: got w_en=%b w_data=%h pressed=%b expected 0 00 0", w_en, w_data, pressed);
      end
      reset = 1'b0;
      run_cycles(30, p1, h2, d);
      tests_run++;
      if (p1 != 0 || h2 != 0 || w_data !== 8'h00) begin
         tests_failed++;
         $display("FAIL after_reset: got pulses=%0d pressed_cycles=%0d w_data=%h expected 0 0 00", p1, h2, w_data);
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_glitch();
      test_store_wrap();
      test_addr_filter();
      test_back_to_back();
      test_bounce_and_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/button_write_ctrl.md
Name: button_write_ctrl

Overview:
Upstream write-source stage for the 8-bit data register. It turns a raw push-button into debounced press events and keeps an 8-bit press count. It merges those writes with core stores to the MMIO address. It drives one write port (w_data/w_en) into the downstream register.

Parameters:
DATA_WIDTH, 8, width of count, store data and w_data
DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required for press/release (min 2)
MMIO_ADDR, 255, store address that writes the register directly
ADDR_WIDTH, 8, width of addr

Ports:
clock  input  1  single system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
button  input  1  raw asynchronous push-button level, 1 = pressed
addr  input  ADDR_WIDTH  core store address
reg_w_en  input  1  core store strobe, valid for one cycle
store_data  input  DATA_WIDTH  core store data
w_data  output  DATA_WIDTH  write data to downstream register
w_en  output  1  one-cycle write strobe to downstream register
pressed  output  1  debounced button level

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset). Both are fixed.
- Reset: sync FFs=0, FSM=IDLE, deb_cnt=0, count=0, pending=0, w_data=0, w_en=0, pressed=0. Reset mid-debounce discards the press; no write is issued.
- Synchronizer: 2-FF chain on button; sync_btn = second FF output.
- Debounce FSM:
  - IDLE: sync_btn=1 -> PRESS_WAIT, deb_cnt=0.
  - PRESS_WAIT: sync_btn=0 -> IDLE. Else if deb_cnt==DEBOUNCE_CYCLES-1 -> PRESSED with press_event for this edge. Else deb_cnt+1.
  - PRESSED: sync_btn=0 -> RELEASE_WAIT, deb_cnt=0.
  - RELEASE_WAIT: sync_btn=1 -> PRESSED with no new event (bounce). Else if deb_cnt==DEBOUNCE_CYCLES-1 -> IDLE. Else deb_cnt+1.
- pressed=1 in PRESSED and RELEASE_WAIT.
- Press latency: the first edge that samples button=1 is edge 1. With button held, the transition to PRESSED occurs at edge DEBOUNCE_CYCLES+3 (edge 19 at default). w_en is high for the following cycle.
- core_store = reg_w_en && addr==MMIO_ADDR. Only this address matches; any other address has no effect.
- Write arbitration, registered outputs, evaluated each edge:
  - core_store only: count<=store_data, w_data<=store_data, w_en<=1.
  - press_event or pending, no core_store: count<=count+1 (mod 2^DATA_WIDTH, 255->0), w_data<=count+1, w_en<=1, pending<=0.
  - core_store together with press_event: core wins; pending<=1; the button write issues on the next edge using the new count, i.e. store_data+1.
  - core_store with pending set: core wins again; pending held.
  - Otherwise w_en<=0; w_data holds its last value.
- w_en is never high for more than one cycle per event. Back-to-back writes are allowed, only in the collision case.

Decomposition:
- Package button_write_pkg: FSM state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT), default MMIO_ADDR constant, DATA_WIDTH default.
- Sub-module button_debouncer: synchronizer plus FSM. Outputs press_event and pressed.
- Top holds the counter, arbitration and pending flag.

Test Plan:
- Reset, then button held high from edge 1 (D=16) -> w_en single pulse after edge 19, w_data=1; pressed=1.
- Button glitch high for 10 cycles, then low -> no w_en, pressed stays 0, count unchanged. Second clean press -> w_data=1.
- Store addr=255, data=0xFE, then two clean presses -> w_data 0xFE, 0xFF, 0x00 (wrap).
- Store addr=254, data=0x55 -> no w_en. Store addr=255 with reg_w_en=0 -> no w_en.
- Store addr=255, data=0x10 on the press_event edge -> w_en two consecutive cycles, w_data 0x10 then 0x11. Repeat with a second store on the pending edge -> pending write delayed one more cycle.
- Release bounce (low 5 cycles, high again) while PRESSED -> no new event; reset asserted during PRESS_WAIT -> all outputs 0, no write after reset release while button low.
